// File: rtl/radio_acquire_axis.sv
`default_nettype none
// radio_acquire_axis: packs 1-bit per-antenna I/Q samples into WIDTH-bit AXI-Stream
// beats framed by tlast, with a one-entry holding register, and drives the radio reconfig line.
module radio_acquire_axis #(
  parameter int ANTENNAS        = 24,
  parameter int WIDTH           = 8,
  parameter int FRAME_LEN       = 1024,
  parameter int RECONFIG_PERIOD = 13_500_000,
  parameter bit RECONFIG_PULSE  = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                strobe_i,
  input  logic [ANTENNAS-1:0] ant_i_i,
  input  logic [ANTENNAS-1:0] ant_q_i,
  output logic                m_tvalid_o,
  input  logic                m_tready_i,
  output logic                m_tlast_o,
  output logic [WIDTH-1:0]    m_tdata_o,
  output logic                reconfig_o,
  output logic                overflow_o,
  output logic [15:0]         dropped_o,
  output logic                busy_o
);

  localparam int BEATS   = (2 * ANTENNAS + WIDTH - 1) / WIDTH;
  localparam int WORD_W  = BEATS * WIDTH;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int FRAME_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAME_LEN - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]         state;
  logic [0:0]         state_next;
  logic               hold_full;
  logic [WORD_W-1:0]  hold_word;
  logic [WORD_W-1:0]  word_in;
  logic [WORD_W-1:0]  shreg;
  logic [BEAT_W-1:0]  beat;
  logic [FRAME_W-1:0] frame_cnt;
  logic               sample_last;
  logic               capture;
  logic               handshake;
  logic               last_hs;
  logic               load;
  logic               drop;

  always_comb begin
    word_in = '0;
    word_in[2*ANTENNAS-1:0] = {ant_q_i, ant_i_i};
  end

  assign capture   = strobe_i && enable_i;
  assign handshake = m_tvalid_o && m_tready_i;
  assign last_hs   = handshake && (beat == LAST_BEAT);
  assign load      = hold_full && ((state == IDLE) || last_hs);
  // A load frees the holding slot on the same edge, so a coincident strobe is kept.
  assign drop      = capture && hold_full && !load;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hold_full) state_next = SEND;
      SEND:    if (last_hs) state_next = hold_full ? SEND : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m_tvalid_o = (state == SEND);
    m_tlast_o  = m_tvalid_o && sample_last && (beat == LAST_BEAT);
    busy_o     = m_tvalid_o || hold_full;
  end

  assign m_tdata_o = shreg[WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_full <= 1'b0;
      hold_word <= '0;
    end else if (capture && (!hold_full || load)) begin
      hold_full <= 1'b1;
      hold_word <= word_in;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg       <= '0;
      beat        <= '0;
      sample_last <= 1'b0;
      frame_cnt   <= '0;
    end else if (load) begin
      shreg       <= hold_word;
      beat        <= '0;
      sample_last <= (frame_cnt == LAST_FRAME);
      frame_cnt   <= (frame_cnt == LAST_FRAME) ? '0 : frame_cnt + FRAME_W'(1);
    end else if (handshake && !last_hs) begin
      shreg <= shreg >> WIDTH;
      beat  <= beat + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
      dropped_o  <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (dropped_o != 16'hFFFF) dropped_o <= dropped_o + 16'd1;
    end
  end

  generate
    if (RECONFIG_PERIOD == 0) begin : g_no_reconfig
      assign reconfig_o = 1'b0;
    end else begin : g_reconfig
      localparam int RC_W = (RECONFIG_PERIOD > 1) ? $clog2(RECONFIG_PERIOD) : 1;
      localparam logic [RC_W-1:0] RC_LAST = RC_W'(RECONFIG_PERIOD - 1);
      logic [RC_W-1:0] rc_cnt;
      logic            rc_out;
      logic            rc_tc;

      assign rc_tc = (rc_cnt == RC_LAST);

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rc_cnt <= '0;
          rc_out <= 1'b0;
        end else begin
          rc_cnt <= rc_tc ? '0 : rc_cnt + RC_W'(1);
          rc_out <= RECONFIG_PULSE ? rc_tc : (rc_out ^ rc_tc);
        end
      end

      assign reconfig_o = rc_out;
    end
  endgenerate

endmodule
`default_nettype wire
